scc_run_ctrl: RTL and testbench

- Synthesizable run controller for one or more scc_f25_top cores, replacing hand-written reset/clk_en sequencing.
- Holds the cores in reset for a programmed number of cycles, then enables them.
- Counts enabled cycles and stops on halt, error or cycle budget.
- Reports a latched status word, sits between the host/bench stimulus and the cores' clk/clk_en/rst pins.

---
 rtl/scc_run_ctrl.sv | 142 ++++++++++++++
 tb/tb_scc_run_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scc_run_ctrl.sv
// Run controller for scc_f25_top cores: reset hold, enabled-cycle counting, stop on error/halt/budget.
// Optional single-step gating is compiled in with `define SCC_RUN_STEP_EN (adds step_mode/step ports).
module scc_run_ctrl #(
  parameter int NUM_CORES  = 1,
  parameter int ERR_W      = 2,
  parameter int RST_CYCLES = 3,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       clear,
`ifdef SCC_RUN_STEP_EN
  input  logic                       step_mode,
  input  logic                       step,
`endif
  input  logic [NUM_CORES-1:0]       halt_f,
  input  logic [NUM_CORES*ERR_W-1:0] err_bits,
  output logic                       core_rst,
  output logic                       core_clk_en,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 status,
  output logic [2:0]                 err_core,
  output logic [NUM_CORES-1:0]       halted_mask,
  output logic [CNT_W-1:0]           cycle_count
);
  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]  RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [CNT_W:0]   MAX_C   = (CNT_W+1)'(MAX_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;
  state_t state;
  logic [RC_W-1:0] rst_cnt;

  logic [NUM_CORES-1:0] core_err;
  logic                 err_any, all_halt, timeout, en_nxt;
  logic [2:0]           err_idx;
  logic [NUM_CORES-1:0] hm_nxt;
  logic [CNT_W:0]       cnt_p1;
  logic [CNT_W-1:0]     cnt_nxt;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_err
    assign core_err[i] = |err_bits[i*ERR_W +: ERR_W];
  end

  // Scan from the top so the lowest-numbered erroring core wins.
  always_comb begin
    err_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (core_err[i]) err_idx = 3'(i);
  end

  assign err_any  = |core_err;
  assign hm_nxt   = halted_mask | halt_f;
  assign all_halt = &hm_nxt;
  assign cnt_p1   = {1'b0, cycle_count} + (CNT_W+1)'(1);
  assign cnt_nxt  = cnt_p1[CNT_W] ? cycle_count : cnt_p1[CNT_W-1:0];
  assign timeout  = (MAX_CYCLES != 0) && (cnt_p1 == MAX_C);

`ifdef SCC_RUN_STEP_EN
  assign en_nxt = step_mode ? step : 1'b1;
`else
  assign en_nxt = 1'b1;
`endif

  // core_clk_en doubles as "this edge is an enabled edge" while in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      core_rst    <= 1'b1;
      core_clk_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      status      <= 2'b00;
      err_core    <= 3'd0;
      halted_mask <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          core_rst    <= 1'b1;
          core_clk_en <= 1'b0;
          if (start) begin
            state       <= S_RESET;
            busy        <= 1'b1;
            rst_cnt     <= '0;
            status      <= 2'b00;
            err_core    <= 3'd0;
            halted_mask <= '0;
            cycle_count <= '0;
          end
        end
        S_RESET: begin
          if (rst_cnt == RC_LAST) begin
            state       <= S_RUN;
            core_rst    <= 1'b0;
            core_clk_en <= en_nxt;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        S_RUN: begin
          core_clk_en <= en_nxt;
          if (core_clk_en) begin
            halted_mask <= hm_nxt;
            cycle_count <= cnt_nxt;
            if (err_any || all_halt || timeout) begin
              state       <= S_DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              core_clk_en <= 1'b0;
              if (err_any) begin
                status   <= 2'b10;
                err_core <= err_idx;
              end else if (all_halt) begin
                status <= 2'b01;
              end else begin
                status <= 2'b11;
              end
            end
          end
        end
        S_DONE: begin
          core_clk_en <= 1'b0;
          if (clear) begin
            state       <= S_IDLE;
            core_rst    <= 1'b1;
            done        <= 1'b0;
            status      <= 2'b00;
            err_core    <= 3'd0;
            halted_mask <= '0;
            cycle_count <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scc_run_ctrl.sv
// Bench for scc_run_ctrl: expected stop records are queued by stimulus and checked by a done monitor.
module tb_scc_run_ctrl;
  logic clk = 1'b0;
  logic rst, start, clear;
  logic step_mode, step;
  logic [1:0] halt_f;
  logic [3:0] err_bits;

  logic a_rst_o, a_en, a_busy, a_done;
  logic [1:0] a_status, a_hm;
  logic [2:0] a_ec;
  logic [31:0] a_cc;
  logic b_rst_o, b_en, b_busy, b_done;
  logic [1:0] b_status, b_hm;
  logic [2:0] b_ec;
  logic [31:0] b_cc;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0]  status;
    logic [2:0]  err_core;
    logic [1:0]  hm;
    logic [31:0] cc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  scc_run_ctrl #(.NUM_CORES(2), .ERR_W(2), .RST_CYCLES(3), .CNT_W(32), .MAX_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
`ifdef SCC_RUN_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .halt_f(halt_f), .err_bits(err_bits),
    .core_rst(a_rst_o), .core_clk_en(a_en), .busy(a_busy), .done(a_done),
    .status(a_status), .err_core(a_ec), .halted_mask(a_hm), .cycle_count(a_cc));

  scc_run_ctrl #(.NUM_CORES(2), .ERR_W(2), .RST_CYCLES(3), .CNT_W(32), .MAX_CYCLES(0)) dut_nolim (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
`ifdef SCC_RUN_STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .halt_f(halt_f), .err_bits(err_bits),
    .core_rst(b_rst_o), .core_clk_en(b_en), .busy(b_busy), .done(b_done),
    .status(b_status), .err_core(b_ec), .halted_mask(b_hm), .cycle_count(b_cc));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!a_done && n < lim) begin
      tick();
      n++;
    end
    chk("wait_done_timeout", {63'd0, a_done}, 64'd1);
  endtask

  task automatic push(input logic [1:0] s, input logic [2:0] e, input logic [1:0] h, input logic [31:0] c);
    exp_t x;
    x.status = s; x.err_core = e; x.hm = h; x.cc = c;
    exp_q.push_back(x);
  endtask

  // Monitor: every rising done pops one expected stop record.
  logic done_q = 1'b0;
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (a_done && !done_q) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          x = exp_q.pop_front();
          chk("mon_status", {62'd0, a_status}, {62'd0, x.status});
          chk("mon_err_core", {61'd0, a_ec}, {61'd0, x.err_core});
          chk("mon_halted_mask", {62'd0, a_hm}, {62'd0, x.hm});
          chk("mon_cycle_count", {32'd0, a_cc}, {32'd0, x.cc});
          chk("mon_clk_en_off", {63'd0, a_en}, 64'd0);
          chk("mon_busy_off", {63'd0, a_busy}, 64'd0);
        end
      end
      done_q = a_done;
    end
  end

  initial begin
    int n;
    int guard;
    rst = 1'b0; start = 1'b0; clear = 1'b0; step_mode = 1'b0; step = 1'b0;
    halt_f = '0; err_bits = '0;
    repeat (2) tick();
    chk("rst_core_rst", {63'd0, a_rst_o}, 64'd1);
    chk("rst_clk_en", {63'd0, a_en}, 64'd0);
    chk("rst_busy_done", {62'd0, a_busy, a_done}, 64'd0);
    chk("rst_status", {62'd0, a_status}, 64'd0);
    chk("rst_cycle_count", {32'd0, a_cc}, 64'd0);
    rst = 1'b1;
    tick();

    // Reset hold length, then run to the cycle budget.
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (a_rst_o && n < 10) begin
      n++;
      tick();
    end
    chk("core_rst_hold", n, 3);
    chk("run_entry_clk_en", {63'd0, a_en}, 64'd1);
    chk("run_entry_busy", {63'd0, a_busy}, 64'd1);
    push(2'b11, 3'd0, 2'b00, 32'd100);
    n = 0; guard = 0;
    while (!a_done && guard < 200) begin
      if (a_en) n++;
      tick();
      guard++;
    end
    chk("timeout_reached", {63'd0, a_done}, 64'd1);
    chk("enabled_cycles", n, 100);
    do_clear();
    chk("clear_idle", {60'd0, a_done, a_busy, a_status}, 64'd0);
    chk("clear_core_rst", {63'd0, a_rst_o}, 64'd1);
    chk("clear_cycle_count", {32'd0, a_cc}, 64'd0);

    // Staggered halts.
    start_run();
    repeat (9) tick();
    halt_f = 2'b01;
    tick();
    halt_f = 2'b00;
    repeat (14) tick();
    halt_f = 2'b10;
    push(2'b01, 3'd0, 2'b11, 32'd25);
    tick();
    halt_f = 2'b00;
    chk("halt_done", {63'd0, a_done}, 64'd1);
    do_clear();

    // Error outranks a simultaneous all-halt.
    start_run();
    repeat (39) tick();
    halt_f = 2'b11;
    err_bits = 4'b1000;
    push(2'b10, 3'd1, 2'b11, 32'd40);
    tick();
    halt_f = 2'b00;
    err_bits = 4'b0000;
    wait_done(5);

    // Lone start in DONE is ignored; start+clear goes to IDLE.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_ignored", {63'd0, a_done}, 64'd1);
    chk("done_status_kept", {62'd0, a_status}, 64'd2);
    chk("done_count_kept", {32'd0, a_cc}, 64'd40);
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    chk("collide_idle", {63'd0, a_done | a_busy}, 64'd0);
    chk("collide_cleared", {25'd0, a_status, a_ec, a_hm, a_cc}, 64'd0);
    tick();
    chk("collide_stays_idle", {63'd0, a_busy}, 64'd0);

    // Two cores erroring: lowest index reported.
    start_run();
    repeat (4) tick();
    err_bits = 4'b0101;
    push(2'b10, 3'd0, 2'b00, 32'd5);
    tick();
    err_bits = 4'b0000;
    wait_done(5);
    do_clear();

    // Async reset in the middle of a cycle.
    start_run();
    repeat (50) tick();
    chk("pre_async_count", {32'd0, a_cc}, 64'd50);
    #2 rst = 1'b0;
    #1;
    chk("async_core_rst", {63'd0, a_rst_o}, 64'd1);
    chk("async_clk_en", {63'd0, a_en}, 64'd0);
    chk("async_count", {32'd0, a_cc}, 64'd0);
    chk("async_busy", {63'd0, a_busy}, 64'd0);
    rst = 1'b1;
    tick();

    // Unlimited budget keeps running long after the limited one times out.
    push(2'b11, 3'd0, 2'b00, 32'd100);
    start_run();
    repeat (1010) tick();
    chk("nolim_busy", {63'd0, b_busy}, 64'd1);
    chk("nolim_not_done", {63'd0, b_done}, 64'd0);
    chk("nolim_count", {32'd0, b_cc}, 64'd1010);
    chk("nolim_clk_en", {63'd0, b_en}, 64'd1);

`ifdef SCC_RUN_STEP_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    step_mode = 1'b1;
    start_run();
    n = 0;
    for (int p = 0; p < 5; p++) begin
      step = 1'b1;
      tick();
      if (a_en) n++;
      step = 1'b0;
      tick();
      if (a_en) n++;
      tick();
      if (a_en) n++;
    end
    repeat (3) tick();
    chk("step_en_cycles", n, 5);
    chk("step_count", {32'd0, a_cc}, 64'd5);
    chk("step_busy", {63'd0, a_busy}, 64'd1);
    step_mode = 1'b0;
`endif

    repeat (2) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
